alu_seq_mul: RTL and testbench

Parametrised sequential ALU with an iterative shift-add multiplier. It accepts one operation per start pulse, registers the result and signals completion with a single-cycle done pulse. Logic and arithmetic ops complete in one cycle; unsigned multiply takes WIDTH cycles and returns a 2×WIDTH product. It replaces the combinational 32-bit ALU in the ALU-with-multiplier datapath, where the controller drives start/op and waits for done.

---
 rtl/alu_seq_mul.sv | 148 ++++++++++++++
 tb/tb_alu_seq_mul.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_mul.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// unsigned multiplier producing a 2*WIDTH product. WIDTH must be a power of two, >= 4.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [3:0]     OP_MUL   = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic               alu_err;
  logic [WIDTH:0]     add_full, sub_full, step_sum;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    shamt    = b[SHW-1:0];
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} - {1'b0, b};
    alu_lo   = '0;
    alu_hi   = '0;
    alu_err  = 1'b0;
    case (op)
      4'h0: alu_lo = ~a;
      4'h1: alu_lo = ~b;
      4'h2: alu_lo = a & b;
      4'h3: alu_lo = a | b;
      4'h4: alu_lo = a ^ b;
      4'h5: alu_lo = ~(a ^ b);
      4'h6: alu_lo = a << shamt;
      4'h7: alu_lo = a >> shamt;
      4'h8: alu_lo = $unsigned($signed(a) >>> shamt);
      4'h9: begin
        alu_lo = add_full[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
      end
      4'hA: begin
        // The extra top bit of the widened difference is exactly the unsigned borrow.
        alu_lo = sub_full[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, sub_full[WIDTH]};
      end
      OP_MUL: alu_lo = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Accumulator upper half collects partial sums; lower half holds the
  // remaining multiplier bits and fills with product bits as it shifts right.
  always_comb begin
    step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {step_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;
    case (state_q)
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          lo_d    = acc_step[WIDTH-1:0];
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            lo_d    = alu_lo;
            hi_d    = alu_hi;
            err_d   = alu_err;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == MUL);
  assign done      = (state_q == DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Self-checking bench for alu_seq_mul: a 32-bit and an 8-bit instance, both
// compared every cycle against a transaction-level arithmetic model.
module tb_alu_seq_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        startV[2];
  logic [3:0]  opV[2];
  logic [63:0] aV[2];
  logic [63:0] bV[2];
  logic        busyV[2];
  logic        doneV[2];
  logic        errV[2];
  logic [63:0] loV[2];
  logic [63:0] hiV[2];

  logic [31:0] lo32, hi32;
  logic [7:0]  lo8, hi8;

  int widthOf[2] = '{32, 8};
  int checks = 0;
  int failures = 0;

  // Model state: remaining busy cycles, pending product, and the visible outputs.
  int          rem[2];
  logic        expDone[2];
  logic        expErr[2];
  logic [63:0] expLo[2];
  logic [63:0] expHi[2];
  logic [63:0] pendLo[2];
  logic [63:0] pendHi[2];
  logic [63:0] gLo, gHi;
  logic        gErr;

  alu_seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(rst_n), .start(startV[0]), .op(opV[0]),
    .a(aV[0][31:0]), .b(bV[0][31:0]), .busy(busyV[0]), .done(doneV[0]),
    .result_lo(lo32), .result_hi(hi32), .err(errV[0])
  );

  alu_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(rst_n), .start(startV[1]), .op(opV[1]),
    .a(aV[1][7:0]), .b(bV[1][7:0]), .busy(busyV[1]), .done(doneV[1]),
    .result_lo(lo8), .result_hi(hi8), .err(errV[1])
  );

  assign loV[0] = {32'b0, lo32};
  assign hiV[0] = {32'b0, hi32};
  assign loV[1] = {56'b0, lo8};
  assign hiV[1] = {56'b0, hi8};

  always #5 clk = ~clk;

  // Reference result of one operation, straight from the opcode table.
  function automatic void golden(input logic [3:0] op, input logic [63:0] ai,
                                 input logic [63:0] bi, input int w,
                                 output logic [63:0] lo, output logic [63:0] hi,
                                 output logic e);
    logic [63:0] mask, x, y, s;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    x = ai & mask;
    y = bi & mask;
    sh = int'(y % 64'(w));
    lo = 64'd0;
    hi = 64'd0;
    e = 1'b0;
    case (op)
      4'd0: lo = ~x & mask;
      4'd1: lo = ~y & mask;
      4'd2: lo = x & y;
      4'd3: lo = x | y;
      4'd4: lo = x ^ y;
      4'd5: lo = ~(x ^ y) & mask;
      4'd6: lo = (x << sh) & mask;
      4'd7: lo = x >> sh;
      4'd8: begin
        lo = x >> sh;
        if (x[w-1]) lo = lo | (mask & ~(mask >> sh));
      end
      4'd9: begin
        s = x + y;
        lo = s & mask;
        hi = s >> w;
      end
      4'd10: begin
        lo = (x - y) & mask;
        hi = (x < y) ? 64'd1 : 64'd0;
      end
      4'd11: begin
        s = x * y;
        lo = s & mask;
        hi = (s >> w) & mask;
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Transaction model: accepts a start whenever no multiply is outstanding.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        rem[k] = 0;
        expDone[k] = 1'b0;
        expErr[k] = 1'b0;
        expLo[k] = 64'd0;
        expHi[k] = 64'd0;
      end else begin
        expDone[k] = 1'b0;
        if (rem[k] > 0) begin
          rem[k] = rem[k] - 1;
          if (rem[k] == 0) begin
            expLo[k] = pendLo[k];
            expHi[k] = pendHi[k];
            expErr[k] = 1'b0;
            expDone[k] = 1'b1;
          end
        end else if (startV[k]) begin
          golden(opV[k], aV[k], bV[k], widthOf[k], gLo, gHi, gErr);
          if (opV[k] == 4'd11) begin
            rem[k] = widthOf[k];
            pendLo[k] = gLo;
            pendHi[k] = gHi;
          end else begin
            expLo[k] = gLo;
            expHi[k] = gHi;
            expErr[k] = gErr;
            expDone[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input int k, input string name,
                             input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (w%0d) got=0x%0h expected=0x%0h at %0t",
               name, widthOf[k], act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput(k, "busy", {63'b0, busyV[k]}, {63'b0, rem[k] > 0});
        checkOutput(k, "done", {63'b0, doneV[k]}, {63'b0, expDone[k]});
        checkOutput(k, "result_lo", loV[k], expLo[k]);
        checkOutput(k, "result_hi", hiV[k], expHi[k]);
        checkOutput(k, "err", {63'b0, errV[k]}, {63'b0, expErr[k]});
      end
    end
  end

  // Called at a falling edge; holds start for one rising edge then scrambles inputs.
  task automatic applyStimulus(input int k, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b);
    startV[k] = 1'b1;
    opV[k] = op;
    aV[k] = a;
    bV[k] = b;
    @(negedge clk);
    startV[k] = 1'b0;
    opV[k] = 4'($urandom);
    aV[k] = (k == 0) ? {32'b0, $urandom} : {56'b0, 8'($urandom)};
    bV[k] = (k == 0) ? {32'b0, $urandom} : {56'b0, 8'($urandom)};
  endtask

  task automatic waitDone(input int k, output int cycles, output int busyCycles);
    cycles = 0;
    busyCycles = 0;
    while (!doneV[k] && cycles < widthOf[k] + 4) begin
      if (busyV[k]) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    if (!doneV[k]) checkOutput(k, "done_timeout", 64'd0, 64'd1);
  endtask

  task automatic checkZero(input int k, input string tag);
    checkOutput(k, {tag, "_busy"}, {63'b0, busyV[k]}, 64'd0);
    checkOutput(k, {tag, "_done"}, {63'b0, doneV[k]}, 64'd0);
    checkOutput(k, {tag, "_lo"}, loV[k], 64'd0);
    checkOutput(k, {tag, "_hi"}, hiV[k], 64'd0);
    checkOutput(k, {tag, "_err"}, {63'b0, errV[k]}, 64'd0);
  endtask

  initial begin
    int c, bc;
    logic [63:0] edgeVals[4];
    for (int k = 0; k < 2; k++) begin
      startV[k] = 1'b0;
      opV[k] = 4'd0;
      aV[k] = 64'd0;
      bV[k] = 64'd0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkZero(0, "reset");
    checkZero(1, "reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 4'h9, 64'h5, 64'h16);
    waitDone(0, c, bc);
    checkOutput(0, "add_latency", 64'(c), 64'd0);
    checkOutput(0, "add_lo", loV[0], 64'h1B);
    checkOutput(0, "add_hi", hiV[0], 64'h0);
    checkOutput(0, "add_busy", {63'b0, busyV[0]}, 64'd0);
    @(negedge clk);
    checkOutput(0, "add_done_single", {63'b0, doneV[0]}, 64'd0);

    applyStimulus(0, 4'hA, 64'h5, 64'h16);
    waitDone(0, c, bc);
    checkOutput(0, "sub_lo", loV[0], 64'hFFFF_FFEF);
    checkOutput(0, "sub_hi", hiV[0], 64'h1);

    applyStimulus(0, 4'h8, 64'h8000_0000, 64'h4);
    waitDone(0, c, bc);
    checkOutput(0, "asr_lo", loV[0], 64'hF800_0000);

    applyStimulus(0, 4'hB, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
    waitDone(0, c, bc);
    checkOutput(0, "mul_latency", 64'(c), 64'd32);
    checkOutput(0, "mul_busy_cycles", 64'(bc), 64'd32);
    checkOutput(0, "mul_hi", hiV[0], 64'hFFFF_FFFE);
    checkOutput(0, "mul_lo", loV[0], 64'h1);
    applyStimulus(0, 4'hB, 64'h5, 64'h16);
    waitDone(0, c, bc);
    checkOutput(0, "b2b_latency", 64'(c), 64'd32);
    checkOutput(0, "b2b_lo", loV[0], 64'h6E);
    checkOutput(0, "b2b_hi", hiV[0], 64'h0);

    applyStimulus(0, 4'hB, 64'h1234, 64'h5678);
    repeat (3) @(negedge clk);
    startV[0] = 1'b1;
    opV[0] = 4'h2;
    @(negedge clk);
    startV[0] = 1'b0;
    waitDone(0, c, bc);
    checkOutput(0, "ignored_latency", 64'(c + 4), 64'd32);
    checkOutput(0, "ignored_lo", loV[0], 64'h0626_0060);
    checkOutput(0, "ignored_hi", hiV[0], 64'h0);
    @(negedge clk);
    checkOutput(0, "ignored_no_done", {63'b0, doneV[0]}, 64'd0);

    applyStimulus(0, 4'hB, {32'b0, $urandom}, {32'b0, $urandom});
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkZero(0, "abort");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 4'h9, 64'hFFFF_FFFF, 64'h1);
    waitDone(0, c, bc);
    checkOutput(0, "post_abort_lo", loV[0], 64'h0);
    checkOutput(0, "post_abort_hi", hiV[0], 64'h1);

    applyStimulus(1, 4'hB, 64'hFF, 64'hFF);
    waitDone(1, c, bc);
    checkOutput(1, "mul8_latency", 64'(c), 64'd8);
    checkOutput(1, "mul8_hi", hiV[1], 64'hFE);
    checkOutput(1, "mul8_lo", loV[1], 64'h01);
    applyStimulus(1, 4'hF, 64'h12, 64'h34);
    waitDone(1, c, bc);
    checkOutput(1, "rsv_err", {63'b0, errV[1]}, 64'd1);
    checkOutput(1, "rsv_lo", loV[1], 64'h0);
    checkOutput(1, "rsv_hi", hiV[1], 64'h0);
    applyStimulus(1, 4'h2, 64'hF0, 64'h3C);
    waitDone(1, c, bc);
    checkOutput(1, "and_clears_err", {63'b0, errV[1]}, 64'd0);
    checkOutput(1, "and8_lo", loV[1], 64'h30);

    // Random traffic on both instances, including starts while busy and reserved codes.
    repeat (1500) begin
      for (int k = 0; k < 2; k++) begin
        logic [63:0] m;
        m = (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
        edgeVals[0] = 64'd0;
        edgeVals[1] = m;
        edgeVals[2] = (m >> 1) + 64'd1;
        edgeVals[3] = 64'd1;
        startV[k] = ($urandom_range(0, 2) == 0);
        opV[k] = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom_range(0, 15));
        aV[k] = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)]
                                            : ({32'b0, $urandom} & m);
        bV[k] = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)]
                                            : ({32'b0, $urandom} & m);
      end
      @(negedge clk);
    end
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
